// File: rtl/cam_capture_gen.sv
// Camera DVP capture: oversampled sensor bus -> RGB888 pixels in a FWFT FIFO with sof/eol markers.
// Optional build macro CAM_TESTPAT_EN adds tp_en_i and an 8-bar colour test pattern.
module cam_capture_gen #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        sys_clk_i,
   input  logic        sys_rst_i,
   input  logic        vsync_i,
   input  logic        href_i,
   input  logic        pclk_i,
   input  logic [7:0]  cam_data_i,
   input  logic [1:0]  fmt_i,
`ifdef CAM_TESTPAT_EN
   input  logic        tp_en_i,
`endif
   input  logic        pix_ready_i,
   output logic        pix_valid_o,
   output logic [7:0]  cam_red_o,
   output logic [7:0]  cam_green_o,
   output logic [7:0]  cam_blue_o,
   output logic        pix_sof_o,
   output logic        pix_eol_o,
   output logic        frame_done_o,
   output logic [15:0] frame_cnt_o,
   output logic        overflow_o,
   output logic        err_line_o
);

   localparam int unsigned PCW = ($clog2(H_ACTIVE + 1) > 10) ? $clog2(H_ACTIVE + 1) : 10;
   localparam int unsigned LCW = $clog2(V_ACTIVE + 1);
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned SW  = 11;
   localparam int unsigned EW  = 26;

   typedef enum logic [1:0] {
      S_WAIT_VS,
      S_FRAME,
      S_DROP
   } state_t;

   // ---------------- input synchroniser ----------------
   logic [SW-1:0] sync_q [SYNC_STAGES];

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= {vsync_i, href_i, pclk_i, cam_data_i};
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   logic       s_vs;
   logic       s_href;
   logic       s_pclk;
   logic [7:0] s_data;

   assign {s_vs, s_href, s_pclk, s_data} = sync_q[SYNC_STAGES-1];

   logic vs_prev_q;
   logic href_prev_q;
   logic pclk_prev_q;
   logic strobe;
   logic href_fall;
   logic vs_rise;
   logic vs_fall;

   assign strobe    =  s_pclk & ~pclk_prev_q;
   assign href_fall = ~s_href &  href_prev_q;
   assign vs_rise   =  s_vs   & ~vs_prev_q;
   assign vs_fall   = ~s_vs   &  vs_prev_q;

   // ---------------- colour expansion ----------------
   function automatic logic [23:0] expand(input logic [1:0] fmt,
                                          input logic [7:0] hi,
                                          input logic [7:0] lo);
      logic [4:0] r5;
      logic [5:0] g6;
      logic [4:0] b5;
      logic [23:0] rgb;
      r5 = hi[7:3];
      g6 = {hi[2:0], lo[7:5]};
      b5 = lo[4:0];
      case (fmt)
         2'b01:   rgb = {hi[3:0], hi[3:0], lo[7:4], lo[7:4], lo[3:0], lo[3:0]};
         2'b10:   rgb = {hi, hi, hi};
         default: rgb = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
      endcase
      return rgb;
   endfunction

   state_t          state_q;
   logic            phase_q;
   logic [7:0]      hi_q;
   logic [PCW-1:0]  pix_cnt_q;
   logic [LCW-1:0]  line_cnt_q;
   logic [1:0]      fmt_q;
   logic            sof_arm_q;
   logic            stg_vld_q;
   logic [EW-1:0]   stg_q;
   logic            overflow_q;
   logic            frame_done_q;
   logic [15:0]     frame_cnt_q;
   logic            err_line_q;
`ifdef CAM_TESTPAT_EN
   logic            tp_q;
`endif

   logic [23:0] pix_rgb;

   always_comb begin
      pix_rgb = expand(fmt_q, hi_q, s_data);
`ifdef CAM_TESTPAT_EN
      if (tp_q) pix_rgb = {{8{pix_cnt_q[9]}}, {8{pix_cnt_q[8]}}, {8{pix_cnt_q[7]}}};
`endif
   end

   // ---------------- output FIFO pointers ----------------
   logic [AW:0]   wr_ptr_q;
   logic [AW:0]   wr_ptr_d;
   logic [AW:0]   rd_ptr_q;
   logic [AW:0]   rd_ptr_d;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic          fifo_empty;
   logic          fifo_full;
   logic          pop;
   logic          push;
   logic          drop;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = ~fifo_empty & pix_ready_i;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push       = stg_vld_q & (~fifo_full | pop);
   assign drop       = stg_vld_q &  fifo_full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= stg_q;
   end

   // ---------------- capture FSM ----------------
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state_q      <= S_WAIT_VS;
         vs_prev_q    <= 1'b0;
         href_prev_q  <= 1'b0;
         pclk_prev_q  <= 1'b0;
         phase_q      <= 1'b0;
         hi_q         <= '0;
         pix_cnt_q    <= '0;
         line_cnt_q   <= '0;
         fmt_q        <= '0;
         sof_arm_q    <= 1'b0;
         stg_vld_q    <= 1'b0;
         stg_q        <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
         err_line_q   <= 1'b0;
`ifdef CAM_TESTPAT_EN
         tp_q         <= 1'b0;
`endif
      end else begin
         vs_prev_q    <= s_vs;
         href_prev_q  <= s_href;
         pclk_prev_q  <= s_pclk;
         frame_done_q <= 1'b0;
         err_line_q   <= 1'b0;
         stg_vld_q    <= 1'b0;
         if (drop) overflow_q <= 1'b1;

         case (state_q)
            S_WAIT_VS: begin
               phase_q   <= 1'b0;
               pix_cnt_q <= '0;
               if (vs_fall) begin
                  state_q    <= S_FRAME;
                  fmt_q      <= fmt_i;
                  overflow_q <= 1'b0;
                  sof_arm_q  <= 1'b1;
                  line_cnt_q <= '0;
`ifdef CAM_TESTPAT_EN
                  tp_q       <= tp_en_i;
`endif
               end
            end

            S_FRAME: begin
               if (vs_rise) begin
                  frame_done_q <= 1'b1;
                  frame_cnt_q  <= frame_cnt_q + 16'd1;
                  state_q      <= S_WAIT_VS;
               end else begin
                  if (drop) state_q <= S_DROP;
                  if (href_fall) begin
                     phase_q    <= 1'b0;
                     pix_cnt_q  <= '0;
                     err_line_q <= (pix_cnt_q != PCW'(H_ACTIVE));
                     if (line_cnt_q != LCW'(V_ACTIVE)) line_cnt_q <= line_cnt_q + 1'b1;
                  end else if (strobe && s_href) begin
                     phase_q <= ~phase_q;
                     if (!phase_q) begin
                        hi_q <= s_data;
                     end else begin
                        stg_vld_q <= 1'b1;
                        stg_q     <= {sof_arm_q, (pix_cnt_q == PCW'(H_ACTIVE - 1)), pix_rgb};
                        sof_arm_q <= 1'b0;
                        pix_cnt_q <= pix_cnt_q + 1'b1;
                     end
                  end
               end
            end

            S_DROP: begin
               if (vs_rise) begin
                  frame_done_q <= 1'b1;
                  frame_cnt_q  <= frame_cnt_q + 16'd1;
                  state_q      <= S_WAIT_VS;
               end
            end

            default: state_q <= S_WAIT_VS;
         endcase
      end
   end

   // ---------------- outputs ----------------
   logic [EW-1:0] head;

   assign head         = mem_q[rd_ptr_q[AW-1:0]];
   assign pix_valid_o  = ~fifo_empty;
   assign {pix_sof_o, pix_eol_o, cam_red_o, cam_green_o, cam_blue_o} =
          pix_valid_o ? head : '0;
   assign frame_done_o = frame_done_q;
   assign frame_cnt_o  = frame_cnt_q;
   assign overflow_o   = overflow_q;
   assign err_line_o   = err_line_q;

endmodule

// File: tb/tb_cam_capture_gen.sv
// Scoreboard bench for cam_capture_gen with H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=16.
module tb_cam_capture_gen;

   localparam int unsigned H = 4;
   localparam int unsigned DEPTH = 16;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        vsync;
   logic        href;
   logic        pclk;
   logic [7:0]  cam_data;
   logic [1:0]  fmt;
   logic        pix_ready;
   logic        pix_valid_o;
   logic [7:0]  cam_red_o;
   logic [7:0]  cam_green_o;
   logic [7:0]  cam_blue_o;
   logic        pix_sof_o;
   logic        pix_eol_o;
   logic        frame_done_o;
   logic [15:0] frame_cnt_o;
   logic        overflow_o;
   logic        err_line_o;

   cam_capture_gen #(
      .H_ACTIVE    (4),
      .V_ACTIVE    (2),
      .FIFO_DEPTH  (16),
      .SYNC_STAGES (2)
   ) dut (
      .sys_clk_i    (sys_clk),
      .sys_rst_i    (sys_rst),
      .vsync_i      (vsync),
      .href_i       (href),
      .pclk_i       (pclk),
      .cam_data_i   (cam_data),
      .fmt_i        (fmt),
      .pix_ready_i  (pix_ready),
      .pix_valid_o  (pix_valid_o),
      .cam_red_o    (cam_red_o),
      .cam_green_o  (cam_green_o),
      .cam_blue_o   (cam_blue_o),
      .pix_sof_o    (pix_sof_o),
      .pix_eol_o    (pix_eol_o),
      .frame_done_o (frame_done_o),
      .frame_cnt_o  (frame_cnt_o),
      .overflow_o   (overflow_o),
      .err_line_o   (err_line_o)
   );

   always #5 sys_clk = ~sys_clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [25:0] exp_q [$];
   int unsigned m_state;      // 0 waiting for frame, 1 in frame, 2 dropping
   logic [1:0]  m_fmt;
   logic        m_sof;
   int unsigned m_pcnt;
   int unsigned exp_frames;   // since last reset
   int unsigned exp_fd;
   int unsigned exp_err;
   logic        exp_ovf;

   function automatic logic [23:0] model_rgb(input logic [1:0] f, input logic [7:0] hi,
                                             input logic [7:0] lo);
      int unsigned r, g, b;
      case (f)
         2'b01: begin
            r = 32'(hi) % 16;
            g = 32'(lo) / 16;
            b = 32'(lo) % 16;
            return {8'(r * 17), 8'(g * 17), 8'(b * 17)};
         end
         2'b10: return {hi, hi, hi};
         default: begin
            r = 32'(hi) / 8;
            g = (32'(hi) % 8) * 8 + 32'(lo) / 32;
            b = 32'(lo) % 32;
            return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
         end
      endcase
   endfunction

   task automatic model_pixel(input logic [7:0] hi, input logic [7:0] lo);
      if (m_state == 1) begin
         if (exp_q.size() >= DEPTH) begin
            m_state = 2;
            exp_ovf = 1'b1;
         end else begin
            exp_q.push_back({m_sof, (m_pcnt == H - 1), model_rgb(m_fmt, hi, lo)});
            m_sof = 1'b0;
         end
         m_pcnt++;
      end
   endtask

   // ---------------- monitor ----------------
   int unsigned fd_seen  = 0;
   int unsigned err_seen = 0;
   int unsigned pix_seen = 0;
   logic [25:0] exp_e;

   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         if (frame_done_o) fd_seen++;
         if (err_line_o)   err_seen++;
         if (pix_valid_o && pix_ready) begin
            pix_seen++;
            if (exp_q.size() == 0) begin
               check("unexpected_pix", 32'd1, 32'd0);
            end else begin
               exp_e = exp_q.pop_front();
               check("pix", {6'd0, pix_sof_o, pix_eol_o, cam_red_o, cam_green_o, cam_blue_o},
                     {6'd0, exp_e});
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      cam_data = b;
      pclk = 1'b0;
      repeat (3) tick;
      pclk = 1'b1;
      repeat (3) tick;
   endtask

   task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo);
      send_byte(hi);
      cam_data = lo;
      pclk = 1'b0;
      repeat (3) tick;
      model_pixel(hi, lo);
      pclk = 1'b1;
      repeat (3) tick;
   endtask

   task automatic send_rand_pixels(input int unsigned n);
      logic [7:0] a, b;
      for (int unsigned i = 0; i < n; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         send_pixel(a, b);
      end
   endtask

   task automatic line_begin;
      pclk = 1'b0;
      href = 1'b1;
      repeat (3) tick;
   endtask

   task automatic line_end;
      pclk = 1'b0;
      href = 1'b0;
      if (m_state == 1 && m_pcnt != H) exp_err++;
      m_pcnt = 0;
      repeat (6) tick;
   endtask

   task automatic vs_start;
      pclk = 1'b0;
      href = 1'b0;
      vsync = 1'b1;
      repeat (6) tick;
      vsync = 1'b0;
      m_state = 1;
      m_fmt = fmt;
      m_sof = 1'b1;
      m_pcnt = 0;
      exp_ovf = 1'b0;
      repeat (6) tick;
   endtask

   task automatic vs_end;
      vsync = 1'b1;
      if (m_state != 0) begin
         exp_frames++;
         exp_fd++;
      end
      m_state = 0;
      repeat (6) tick;
   endtask

   task automatic drain;
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick;
      repeat (4) tick;
      check("drain_left", exp_q.size(), 32'd0);
   endtask

   task automatic status(input string tag);
      check({tag, "_frame_cnt"}, {16'd0, frame_cnt_o}, exp_frames);
      check({tag, "_frame_done"}, fd_seen, exp_fd);
      check({tag, "_err_line"}, err_seen, exp_err);
      check({tag, "_overflow"}, {31'd0, overflow_o}, {31'd0, exp_ovf});
   endtask

   int unsigned pix0;

   initial begin
      sys_rst = 1'b1; vsync = 1'b0; href = 1'b0; pclk = 1'b0;
      cam_data = '0; fmt = 2'b00; pix_ready = 1'b0;
      m_state = 0; m_fmt = 2'b00; m_sof = 1'b0; m_pcnt = 0;
      exp_frames = 0; exp_fd = 0; exp_err = 0; exp_ovf = 1'b0;
      repeat (4) tick;
      sys_rst = 1'b0;
      tick;
      @(negedge sys_clk);
      check("rst_outs", {2'b0, pix_valid_o, pix_sof_o, pix_eol_o, cam_red_o, cam_green_o,
                         cam_blue_o, frame_done_o, overflow_o, err_line_o}, 32'd0);
      check("rst_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);

      // Reset mid-line with 5 pixels held; nothing may appear until a new vsync fall.
      vs_start;
      line_begin;
      for (int i = 0; i < 5; i++) send_pixel(8'(i * 16 + 3), 8'(i * 7 + 1));
      repeat (6) tick;
      check("t1_fifo_held", {31'd0, pix_valid_o}, 32'd1);
      sys_rst = 1'b1;
      exp_q.delete();
      m_state = 0; m_pcnt = 0; exp_ovf = 1'b0; exp_frames = 0;
      tick;
      @(negedge sys_clk);
      check("t1_rst_outs", {2'b0, pix_valid_o, pix_sof_o, pix_eol_o, cam_red_o, cam_green_o,
                            cam_blue_o, frame_done_o, overflow_o, err_line_o}, 32'd0);
      tick;
      sys_rst = 1'b0;
      pix_ready = 1'b1;
      send_rand_pixels(2);
      line_end;
      vs_end;
      repeat (10) tick;
      check("t1_no_pix", pix_seen, 32'd0);
      status("t1");

      // Full H_ACTIVE x V_ACTIVE frame in RGB565 with known colours.
      pix0 = pix_seen;
      fmt = 2'b00;
      vs_start;
      line_begin;
      send_pixel(8'hF8, 8'h00);
      send_pixel(8'h07, 8'hE0);
      send_pixel(8'h84, 8'h10);
      send_rand_pixels(1);
      line_end;
      line_begin;
      send_rand_pixels(4);
      line_end;
      vs_end;
      drain;
      check("t3_npix", pix_seen - pix0, 32'd8);
      status("t3");

      // Short line raises err_line and carries no eol.
      vs_start;
      line_begin;
      send_rand_pixels(3);
      line_end;
      line_begin;
      send_rand_pixels(4);
      line_end;
      vs_end;
      drain;
      status("t5");

      // Grey format; a mid-frame fmt change only applies from the next frame.
      fmt = 2'b10;
      vs_start;
      line_begin;
      send_pixel(8'h5A, 8'h80);
      send_rand_pixels(3);
      line_end;
      fmt = 2'b01;
      line_begin;
      send_rand_pixels(4);
      line_end;
      vs_end;
      drain;
      vs_start;
      line_begin;
      send_pixel(8'h0C, 8'h3F);
      send_rand_pixels(3);
      line_end;
      vs_end;
      drain;
      status("t6");

      // Stalled sink: 16 pixels held, rest of frame dropped, frame still counted.
      fmt = 2'b00;
      pix_ready = 1'b0;
      pix0 = pix_seen;
      vs_start;
      line_begin;
      send_rand_pixels(40);
      line_end;
      line_begin;
      send_rand_pixels(4);
      line_end;
      vs_end;
      repeat (6) tick;
      check("t4_valid", {31'd0, pix_valid_o}, 32'd1);
      status("t4_stall");
      pix_ready = 1'b1;
      drain;
      check("t4_npix", pix_seen - pix0, 32'd16);
      check("t4_ovf_sticky", {31'd0, overflow_o}, 32'd1);
      vs_start;
      check("t4_ovf_clear", {31'd0, overflow_o}, 32'd0);
      line_begin;
      send_rand_pixels(4);
      line_end;
      vs_end;
      drain;
      status("t4_end");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
